vm_loader: RTL

Boot-time loader that sits directly upstream of the stack-VM core and its two memories. It accepts a byte stream over a valid/ready handshake, decodes load commands, and writes 12-bit instruction words into program memory and 8-bit bytes into data memory. It holds the core in reset until a GO command arrives, then releases it. The core then fetches from memories whose contents came entirely from the stream.

---
 rtl/vm_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vm_loader.sv
// vm_loader: boot-time byte-stream loader for the stack-VM core.
// Decodes 'P' (program), 'D' (data) and 'G' (go) commands from a valid/ready
// byte stream and writes 12-bit program words / 8-bit data bytes into the
// core's memories. Holds the core in reset until GO is accepted.
//
// Ports:
//   eo3       clock (rising edge)
//   nF3       synchronous active-high reset
//   in_valid  stream byte valid
//   in_data   stream byte
//   in_ready  loader can accept a byte (combinational)
//   pw_en     program memory write strobe (registered, one cycle)
//   pw_addr   program write address
//   pw_data   program write word, [11:8] = opcode
//   dw_en     data memory write strobe (registered, one cycle)
//   dw_addr   data write address
//   dw_data   data write byte
//   core_rst  reset to the VM core, active-high
//   done      GO accepted; held until reset
//   err       protocol error seen; sticky until reset
module vm_loader #(
    parameter int PROG_AW = 8,
    parameter int DATA_AW = 8
) (
    input  logic               eo3,
    input  logic               nF3,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               pw_en,
    output logic [PROG_AW-1:0] pw_addr,
    output logic [11:0]        pw_data,
    output logic               dw_en,
    output logic [DATA_AW-1:0] dw_addr,
    output logic [7:0]         dw_data,
    output logic               core_rst,
    output logic               done,
    output logic               err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_P_ADDR,
        S_P_CNT,
        S_P_HI,
        S_P_LO,
        S_D_ADDR,
        S_D_CNT,
        S_D_BYTE,
        S_RUN,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [PROG_AW-1:0] pa_q, pa_d;
    logic [DATA_AW-1:0] da_q, da_d;
    // 9 bits so that a count byte of 0 can be held as 256 items.
    logic [8:0]         cnt_q, cnt_d;
    logic [3:0]         hi_q, hi_d;

    logic               pw_en_q, pw_en_d;
    logic [PROG_AW-1:0] pw_addr_q, pw_addr_d;
    logic [11:0]        pw_data_q, pw_data_d;
    logic               dw_en_q, dw_en_d;
    logic [DATA_AW-1:0] dw_addr_q, dw_addr_d;
    logic [7:0]         dw_data_q, dw_data_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;

    assign in_ready = !nF3 && (state_q != S_RUN);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        pa_d       = pa_q;
        da_d       = da_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        pw_en_d    = 1'b0;
        pw_addr_d  = pw_addr_q;
        pw_data_d  = pw_data_q;
        dw_en_d    = 1'b0;
        dw_addr_d  = dw_addr_q;
        dw_data_d  = dw_data_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    case (in_data)
                        8'h50: state_d = S_P_ADDR;
                        8'h44: state_d = S_D_ADDR;
                        8'h47: begin
                            state_d    = S_RUN;
                            core_rst_d = 1'b0;
                            done_d     = 1'b1;
                        end
                        default: begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                S_P_ADDR: begin
                    pa_d    = PROG_AW'(in_data);
                    state_d = S_P_CNT;
                end
                S_P_CNT: begin
                    cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    state_d = S_P_HI;
                end
                S_P_HI: begin
                    if (in_data[7:4] != 4'h0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        hi_d    = in_data[3:0];
                        state_d = S_P_LO;
                    end
                end
                S_P_LO: begin
                    pw_en_d   = 1'b1;
                    pw_addr_d = pa_q;
                    pw_data_d = {hi_q, in_data};
                    pa_d      = pa_q + PROG_AW'(1);
                    cnt_d     = cnt_q - 9'd1;
                    state_d   = (cnt_q == 9'd1) ? S_IDLE : S_P_HI;
                end
                S_D_ADDR: begin
                    da_d    = DATA_AW'(in_data);
                    state_d = S_D_CNT;
                end
                S_D_CNT: begin
                    cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    state_d = S_D_BYTE;
                end
                S_D_BYTE: begin
                    dw_en_d   = 1'b1;
                    dw_addr_d = da_q;
                    dw_data_d = in_data;
                    da_d      = da_q + DATA_AW'(1);
                    cnt_d     = cnt_q - 9'd1;
                    state_d   = (cnt_q == 9'd1) ? S_IDLE : S_D_BYTE;
                end
                // RUN never accepts; ERR drains bytes with no effect.
                default: ;
            endcase
        end
    end

    always_ff @(posedge eo3) begin
        if (nF3) begin
            state_q    <= S_IDLE;
            pa_q       <= '0;
            da_q       <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            pw_en_q    <= 1'b0;
            pw_addr_q  <= '0;
            pw_data_q  <= '0;
            dw_en_q    <= 1'b0;
            dw_addr_q  <= '0;
            dw_data_q  <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pa_q       <= pa_d;
            da_q       <= da_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            pw_en_q    <= pw_en_d;
            pw_addr_q  <= pw_addr_d;
            pw_data_q  <= pw_data_d;
            dw_en_q    <= dw_en_d;
            dw_addr_q  <= dw_addr_d;
            dw_data_q  <= dw_data_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign pw_en    = pw_en_q;
    assign pw_addr  = pw_addr_q;
    assign pw_data  = pw_data_q;
    assign dw_en    = dw_en_q;
    assign dw_addr  = dw_addr_q;
    assign dw_data  = dw_data_q;
    assign core_rst = core_rst_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
